// File: rtl/pc_fetch_ctrl.sv
// Next-PC sequencer and PC write-enable control.
// Holds late redirects across icache misses/stalls; freezes on halt.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             stall,
  input  logic             halt,
  input  logic [31:0]      cur_pc,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_val,
  input  logic             redir_valid,
  input  logic [1:0]       redir_type,
  output logic [31:0]      next_pc,
  output logic             pcWEN,
  output logic             iREN,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic             halted_q;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] tgt;
  logic        adv;
  logic        wen;
  logic        ren;
  logic [31:0] npc;

  assign pc4    = cur_pc + 32'd4;
  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign adv    = ihit & ~stall;

  always_comb begin
    tgt = pc4;
    unique case (redir_type)
      2'b00:   tgt = pc4 + br_off;
      2'b01:   tgt = {pc4[31:28], instr[25:0], 2'b00};
      2'b10:   tgt = rs_val;
      default: tgt = pc4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wen     = 1'b0;
    ren     = 1'b0;
    npc     = pc4;
    unique case (state_q)
      RUN: begin
        ren = 1'b1;
        if (halt && ihit) begin
          npc     = cur_pc;
          state_d = HALTED;
        end else if (adv) begin
          wen = 1'b1;
          npc = redir_valid ? tgt : pc4;
        end else if (redir_valid) begin
          pend_d  = tgt;
          state_d = PEND;
        end
      end
      PEND: begin
        ren = 1'b1;
        npc = pend_q;
        // A redirect arriving now supersedes the one being held.
        if (redir_valid) begin
          pend_d = tgt;
          if (adv) npc = tgt;
        end
        if (adv) begin
          wen     = 1'b1;
          state_d = RUN;
        end
      end
      HALTED: begin
        npc = cur_pc;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= RUN;
      pend_q   <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      halted_q <= (state_d == HALTED);
      if (wen && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  assign next_pc     = nRST ? npc : RESET_PC;
  assign pcWEN       = nRST & wen;
  assign iREN        = nRST & ren;
  assign halted      = nRST & halted_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl.
// Second instance with a 3-bit counter exercises saturation.
module tb_pc_fetch_ctrl;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic        stall;
  logic        halt;
  logic [31:0] cur_pc;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic        redir_valid;
  logic [1:0]  redir_type;

  logic [31:0] next_pc;
  logic        pcWEN;
  logic        iREN;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] s_next_pc;
  logic        s_pcWEN;
  logic        s_iREN;
  logic        s_halted;
  logic [2:0]  s_count;

  int checks;
  int failures;

  pc_fetch_ctrl u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall),
    .halt(halt), .cur_pc(cur_pc), .instr(instr),
    .rs_val(rs_val), .redir_valid(redir_valid),
    .redir_type(redir_type), .next_pc(next_pc),
    .pcWEN(pcWEN), .iREN(iREN), .halted(halted),
    .fetch_count(fetch_count)
  );

  pc_fetch_ctrl #(.CNT_W(3)) u_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall),
    .halt(halt), .cur_pc(cur_pc), .instr(instr),
    .rs_val(rs_val), .redir_valid(redir_valid),
    .redir_type(redir_type), .next_pc(s_next_pc),
    .pcWEN(s_pcWEN), .iREN(s_iREN), .halted(s_halted),
    .fetch_count(s_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 0; stall = 0; halt = 0;
    redir_valid = 0; redir_type = 2'b00;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    nRST = 0; idle(); ihit = 1;
    cur_pc = 32'h0; instr = 32'h0; rs_val = 32'h0;
    #1;
    chk("rst_npc", next_pc, 32'h0);
    chk("rst_wen", {31'b0, pcWEN}, 0);
    chk("rst_ren", {31'b0, iREN}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    tick();
    chk("rst_cnt", fetch_count, 0);

    // 1: sequential fetch
    nRST = 1;
    for (int i = 0; i < 4; i++) begin
      cur_pc = 32'(i * 4);
      #1;
      chk("seq_npc", next_pc, 32'((i + 1) * 4));
      chk("seq_wen", {31'b0, pcWEN}, 1);
      tick();
    end
    chk("seq_cnt", fetch_count, 4);
    chk("seq_scnt", {29'b0, s_count}, 4);

    // 2: taken branch, negative offset, same-cycle
    cur_pc = 32'h100; instr = 32'h0000FFFE;
    redir_valid = 1; redir_type = 2'b00;
    #1;
    chk("br_npc", next_pc, 32'h0FC);
    chk("br_wen", {31'b0, pcWEN}, 1);
    tick();

    // 3: jr during miss -> held for three cycles
    cur_pc = 32'h200; rs_val = 32'h4000;
    redir_type = 2'b10; ihit = 0;
    #1;
    chk("jr_wen0", {31'b0, pcWEN}, 0);
    tick();
    redir_valid = 0; cur_pc = 32'h204; rs_val = 32'h0;
    #1;
    chk("pend_wen1", {31'b0, pcWEN}, 0);
    chk("pend_npc1", next_pc, 32'h4000);
    tick();
    #1;
    chk("pend_wen2", {31'b0, pcWEN}, 0);
    tick();
    ihit = 1;
    #1;
    chk("pend_rel_npc", next_pc, 32'h4000);
    chk("pend_rel_wen", {31'b0, pcWEN}, 1);
    tick();
    cur_pc = 32'h4000;
    #1;
    chk("run_again_npc", next_pc, 32'h4004);
    chk("run_again_wen", {31'b0, pcWEN}, 1);
    tick();
    chk("cnt7", fetch_count, 7);

    // 4: newer redirect replaces the held one; halt ignored in PEND
    cur_pc = 32'h200; rs_val = 32'h4000;
    redir_valid = 1; redir_type = 2'b10; ihit = 0;
    tick();
    cur_pc = 32'h300; instr = 32'h00000010;
    redir_type = 2'b01;
    #1;
    chk("pend_old_npc", next_pc, 32'h4000);
    chk("pend_old_wen", {31'b0, pcWEN}, 0);
    tick();
    redir_valid = 0; ihit = 1; halt = 1;
    #1;
    chk("pend_new_npc", next_pc, 32'h40);
    chk("pend_new_wen", {31'b0, pcWEN}, 1);
    tick();
    halt = 0; cur_pc = 32'h40;
    #1;
    chk("no_halt", {31'b0, halted}, 0);
    chk("run_npc", next_pc, 32'h44);
    tick();

    // 6: wrap and saturation
    cur_pc = 32'hFFFFFFFC;
    #1;
    chk("wrap_npc", next_pc, 32'h0);
    chk("wrap_wen", {31'b0, pcWEN}, 1);
    tick();
    chk("cnt10", fetch_count, 10);
    chk("sat_cnt", {29'b0, s_count}, 7);
    stall = 1; cur_pc = 32'h10;
    #1;
    chk("stall_wen", {31'b0, pcWEN}, 0);
    chk("stall_npc", next_pc, 32'h14);
    tick();
    chk("stall_cnt", fetch_count, 10);

    // 5: halt wins over redirect and adv
    stall = 0; halt = 1; ihit = 1;
    redir_valid = 1; redir_type = 2'b00;
    cur_pc = 32'h500;
    #1;
    chk("halt_wen", {31'b0, pcWEN}, 0);
    chk("halt_npc", next_pc, 32'h500);
    chk("halt_ren", {31'b0, iREN}, 1);
    chk("halt_h0", {31'b0, halted}, 0);
    tick();
    halt = 0; cur_pc = 32'h600;
    #1;
    chk("hd_halted", {31'b0, halted}, 1);
    chk("hd_ren", {31'b0, iREN}, 0);
    chk("hd_wen", {31'b0, pcWEN}, 0);
    chk("hd_npc", next_pc, 32'h600);
    tick();
    redir_valid = 0; ihit = 0;
    #1;
    chk("hd_halted2", {31'b0, halted}, 1);
    chk("hd_cnt", fetch_count, 10);
    nRST = 0;
    #1;
    chk("hd_rst_npc", next_pc, 32'h0);
    chk("hd_rst_h", {31'b0, halted}, 0);
    tick();
    nRST = 1; cur_pc = 32'h0;
    #1;
    chk("post_rst_cnt", fetch_count, 0);
    chk("post_rst_ren", {31'b0, iREN}, 1);
    chk("post_rst_npc", next_pc, 32'h4);
    chk("post_rst_wen", {31'b0, pcWEN}, 0);

    // pending redirect discarded by reset
    redir_valid = 1; redir_type = 2'b10; rs_val = 32'h4000;
    tick();
    idle(); nRST = 0;
    tick();
    nRST = 1; ihit = 1; cur_pc = 32'h0;
    #1;
    chk("disc_npc", next_pc, 32'h4);
    chk("disc_wen", {31'b0, pcWEN}, 1);
    tick();
    chk("disc_cnt", fetch_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
